// File: rtl/residue_reader_luma4x4.sv
// residue_reader_luma4x4
//   Reads back one 4x4 luma block: its 3-bit intra prediction mode and its
//   16 residue bytes. The samples are streamed downstream over valid/ready.
//   Both memories are synchronous-read RAMs with a 1-cycle read latency.
//   A 2-entry output buffer absorbs downstream stalls, so that no read
//   result is ever lost.
//
// Optional feature (compile-time macro RESIDUE_ZIGZAG_EN):
//   defined   -> samples are issued in 4x4 zig-zag order.
//                out_idx still reports the raster index of each sample.
//   undefined -> samples are issued in raster order 0..15.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   start, blknumber     request. It is sampled only in IDLE.
//                        blknumber is the raster index over the 4x4 block grid.
//   busy, done, err      status. done is a 1-cycle pulse.
//                        err (valid with done) flags an out-of-range block.
//   mode_rd_en/addr/rdata     mode memory port (1-cycle read latency)
//   res_rd_en/addr/rdata      residue memory port (1-cycle read latency)
//   out_valid/ready/data/idx/mode/last   output sample stream
module residue_reader_luma4x4 #(
  parameter int LENGTH = 256,
  parameter int WIDTH  = 256,
  parameter int ADDR_W = 16,
  parameter int BLK_W  = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BLK_W-1:0]  blknumber,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mode_rd_en,
  output logic [BLK_W-1:0]  mode_addr,
  input  logic [2:0]        mode_rdata,
  output logic              res_rd_en,
  output logic [ADDR_W-1:0] res_addr,
  input  logic [7:0]        res_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [3:0]        out_idx,
  output logic [2:0]        out_mode,
  output logic              out_last
);

  localparam int AW2    = ADDR_W + 2;
  localparam int BPR    = WIDTH / 4;
  localparam int BPR_SH = $clog2(BPR);
  localparam int W_SH   = $clog2(WIDTH);
  localparam logic [31:0] NBLK = 32'(BPR * (LENGTH / 4));

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_MODE, S_MLAT, S_STREAM, S_DONE
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] idx;
    logic       last;
  } ent_t;

  state_t           state_q, state_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [AW2-1:0]   base_q, base_d;
  logic [2:0]       mode_q, mode_d;
  logic [4:0]       iss_q, iss_d;      // reads issued
  logic [4:0]       hs_q, hs_d;        // handshakes completed
  logic             infl_q, infl_d;    // one read outstanding
  logic [3:0]       infl_idx_q, infl_idx_d;
  logic             infl_last_q, infl_last_d;
  ent_t [1:0]       fifo_q, fifo_d;
  logic             wr_q, wr_d, rd_q, rd_d;
  logic [1:0]       occ_q, occ_d;

  logic [AW2-1:0] brow_w, bcol_w, base_w, samp_off, samp_addr;
  logic [3:0]     samp_idx;
  ent_t           head, arrive;
  logic           head_vld, hs, push, pop, rd_ok;

  // Maps the issue position to the raster index of the sample.
  function automatic logic [3:0] issue_pos(input logic [3:0] k);
`ifdef RESIDUE_ZIGZAG_EN
    case (k)
      4'd0:  return 4'd0;
      4'd1:  return 4'd1;
      4'd2:  return 4'd4;
      4'd3:  return 4'd8;
      4'd4:  return 4'd5;
      4'd5:  return 4'd2;
      4'd6:  return 4'd3;
      4'd7:  return 4'd6;
      4'd8:  return 4'd9;
      4'd9:  return 4'd12;
      4'd10: return 4'd13;
      4'd11: return 4'd10;
      4'd12: return 4'd7;
      4'd13: return 4'd11;
      4'd14: return 4'd14;
      default: return 4'd15;
    endcase
`else
    return k;
`endif
  endfunction

  always_comb begin
    // Block geometry. WIDTH is a power of two, so shifts and masks suffice.
    brow_w    = AW2'(blknumber) >> BPR_SH;
    bcol_w    = AW2'(blknumber) & AW2'(BPR - 1);
    base_w    = (brow_w << (W_SH + 2)) + (bcol_w << 2);
    samp_idx  = issue_pos(iss_q[3:0]);
    samp_off  = (AW2'(samp_idx[3:2]) << W_SH) + AW2'(samp_idx[1:0]);
    samp_addr = base_q + samp_off;

    // RAM data that arrives while the buffer is empty is presented directly.
    // That bypass lets the stream run at one sample per cycle with one read
    // outstanding. On a stall, the data is captured into the buffer in the
    // same cycle, so out_data stays stable afterwards.
    arrive   = '{data: res_rdata, idx: infl_idx_q, last: infl_last_q};
    head_vld = (occ_q != 2'd0) || infl_q;
    head     = (occ_q != 2'd0) ? fifo_q[rd_q] : arrive;
    hs       = head_vld && out_ready;
    pop      = hs && (occ_q != 2'd0);
    push     = infl_q && !(hs && (occ_q == 2'd0));
    rd_ok    = (iss_q < 5'd16) && (({1'b0, occ_q} + {2'b0, infl_q}) < 3'd2);

    state_d     = state_q;
    blk_d       = blk_q;
    base_d      = base_q;
    mode_d      = mode_q;
    iss_d       = iss_q;
    hs_d        = hs_q;
    fifo_d      = fifo_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    occ_d       = occ_q + 2'(push) - 2'(pop);
    done        = 1'b0;
    err         = 1'b0;
    mode_rd_en  = 1'b0;
    res_rd_en   = 1'b0;
    res_addr    = '0;

    if (push) begin
      fifo_d[wr_q] = arrive;
      wr_d         = ~wr_q;
    end
    if (pop) rd_d = ~rd_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          blk_d   = blknumber;
          base_d  = base_w;
          iss_d   = '0;
          hs_d    = '0;
          state_d = (32'(blknumber) >= NBLK) ? S_ERR : S_MODE;
        end
      end
      S_ERR: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = S_IDLE;
      end
      S_MODE: begin
        mode_rd_en = 1'b1;
        state_d    = S_MLAT;
      end
      S_MLAT: begin
        mode_d  = mode_rdata;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (rd_ok) begin
          res_rd_en = 1'b1;
          res_addr  = samp_addr[ADDR_W-1:0];
          iss_d     = iss_q + 5'd1;
        end
        if (hs) begin
          hs_d = hs_q + 5'd1;
          if (hs_q == 5'd15) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    infl_d      = res_rd_en;
    infl_idx_d  = res_rd_en ? samp_idx : infl_idx_q;
    infl_last_d = res_rd_en ? (iss_q == 5'd15) : infl_last_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      blk_q       <= '0;
      base_q      <= '0;
      mode_q      <= '0;
      iss_q       <= '0;
      hs_q        <= '0;
      infl_q      <= 1'b0;
      infl_idx_q  <= '0;
      infl_last_q <= 1'b0;
      fifo_q      <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      base_q      <= base_d;
      mode_q      <= mode_d;
      iss_q       <= iss_d;
      hs_q        <= hs_d;
      infl_q      <= infl_d;
      infl_idx_q  <= infl_idx_d;
      infl_last_q <= infl_last_d;
      fifo_q      <= fifo_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      occ_q       <= occ_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign mode_addr = blk_q;
  assign out_mode  = mode_q;
  assign out_valid = head_vld;
  assign out_data  = head_vld ? head.data : 8'd0;
  assign out_idx   = head_vld ? head.idx  : 4'd0;
  assign out_last  = head_vld && head.last;

endmodule

// File: tb/tb_residue_reader_luma4x4.sv
module tb_residue_reader_luma4x4;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [12:0] blknumber = '0;
  logic        busy, done, err, mode_rd_en, res_rd_en;
  logic [12:0] mode_addr;
  logic [2:0]  mode_rdata = '0;
  logic [15:0] res_addr;
  logic [7:0]  res_rdata = '0;
  logic        out_valid, out_last;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic [3:0]  out_idx;
  logic [2:0]  out_mode;

  residue_reader_luma4x4 dut (
    .clk(clk), .reset(reset), .start(start), .blknumber(blknumber),
    .busy(busy), .done(done), .err(err),
    .mode_rd_en(mode_rd_en), .mode_addr(mode_addr), .mode_rdata(mode_rdata),
    .res_rd_en(res_rd_en), .res_addr(res_addr), .res_rdata(res_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_mode(out_mode), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories
  logic [7:0] res_mem [0:65535];
  logic [2:0] mode_mem [0:8191];
  always @(posedge clk) begin
    if (mode_rd_en) mode_rdata <= mode_mem[mode_addr];
    if (res_rd_en)  res_rdata  <= res_mem[res_addr];
  end

  typedef struct {
    logic [7:0] d;
    logic [3:0] i;
    logic [2:0] m;
    logic       l;
  } exp_t;
  exp_t        exp_q[$];
  int unsigned addr_q[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0;
  int cur_blk = 0;
  int mode_cnt, rd_cnt, req_hs, done_cnt = 0;
  int first_mode, first_rd, first_vld, last_hs;
  int ready_mode = 0, pat = 0;
  bit stall_q = 0;
  logic [12:0] stall_val;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int order(input int k);
`ifdef RESIDUE_ZIGZAG_EN
    int zz[16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
    return zz[k];
`else
    return k;
`endif
  endfunction

  // Reference: the block's 16 samples, in issue order, from the frame geometry
  task automatic build_exp(input int blk);
    int base, r, a;
    exp_t e;
    base = (blk / 64) * 4 * 256 + (blk % 64) * 4;
    for (int k = 0; k < 16; k++) begin
      r = order(k);
      a = (base + (r / 4) * 256 + (r % 4)) % 65536;
      addr_q.push_back(a);
      e.d = res_mem[a];
      e.i = 4'(r);
      e.m = mode_mem[blk];
      e.l = (k == 15);
      exp_q.push_back(e);
    end
  endtask

  // Downstream ready pattern
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = (pat == 0 || pat == 3); pat = (pat + 1) % 4; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (mode_rd_en) begin
        mode_cnt++;
        if (first_mode < 0) first_mode = cyc - start_cyc;
        chk("mode_addr", 32'(mode_addr), 32'(cur_blk));
      end
      if (res_rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc - start_cyc;
        if (addr_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL res_rd_unexpected: got read addr %0d expected no read", res_addr);
        end else chk("res_addr", 32'(res_addr), addr_q.pop_front());
      end
      if (out_valid && first_vld < 0) first_vld = cyc - start_cyc;
      if (stall_q) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_hold", 32'({out_data, out_idx, out_last}), 32'(stall_val));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sample_unexpected: got idx %0d expected no sample", out_idx);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sample", 32'({out_data, out_idx, out_mode, out_last}),
              32'({e.d, e.i, e.m, e.l}));
        end
        req_hs++;
        last_hs = cyc - start_cyc;
      end
      stall_q   = out_valid && !out_ready;
      stall_val = {out_data, out_idx, out_last};
      if (done) done_cnt++;
    end else stall_q = 0;
  end

  task automatic issue(input int blk);
    cur_blk = blk;
    mode_cnt = 0; rd_cnt = 0; req_hs = 0;
    first_mode = -1; first_rd = -1; first_vld = -1; last_hs = -1;
    @(posedge clk); #1;
    blknumber = 13'(blk);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_req(input int blk, input bit exp_err, input bit timing);
    int t, dcyc;
    bit got, derr;
    if (!exp_err) build_exp(blk);
    issue(blk);
    t = 0; got = 0; dcyc = 0; derr = 0;
    while (!got && t < 400) begin
      @(negedge clk); t++;
      if (done) begin got = 1; dcyc = cyc - start_cyc; derr = err; end
    end
    chk("done_seen", 32'(got), 32'd1);
    if (got) chk("err", 32'(derr), 32'(exp_err));
    chk("read_count", rd_cnt, exp_err ? 0 : 16);
    chk("mode_read_count", mode_cnt, exp_err ? 0 : 1);
    chk("samples_left", exp_q.size(), 0);
    if (timing) begin
      if (exp_err) chk("err_cycle", dcyc, 1);
      else begin
        chk("mode_rd_cycle", first_mode, 1);
        chk("first_rd_cycle", first_rd, 3);
        chk("first_valid_cycle", first_vld, 4);
        chk("last_hs_cycle", last_hs, 19);
        chk("done_cycle", dcyc, 20);
      end
    end
    @(negedge clk);
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int d0, t;
    for (int a = 0; a < 65536; a++) res_mem[a] = 8'(a);
    for (int b = 0; b < 8192; b++) mode_mem[b] = 3'($urandom);
    mode_mem[0] = 3'd3;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done_err", 32'({done, err}), 0);
    chk("rst_rd_en", 32'({mode_rd_en, res_rd_en}), 0);
    chk("rst_addr", 32'({mode_addr, res_addr}), 0);
    chk("rst_out", 32'({out_valid, out_data, out_idx, out_mode, out_last}), 0);
    @(posedge clk); #1 reset = 1'b0;

    ready_mode = 0;
    run_req(0, 0, 1);
    run_req(65, 0, 1);
    run_req(4096, 1, 1);

    ready_mode = 1; pat = 0;
    run_req(65, 0, 0);
    run_req(int'($urandom_range(0, 4095)), 0, 0);

    // Abort a request at its 7th handshake
    d0 = done_cnt;
    build_exp(0);
    issue(0);
    t = 0;
    while (req_hs < 7 && t < 400) begin @(negedge clk); t++; end
    chk("abort_reached_hs7", req_hs, 7);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort_rst_out", 32'({busy, out_valid, done}), 0);
    @(posedge clk); #1 reset = 1'b0;
    exp_q.delete(); addr_q.delete();
    chk("abort_no_done", done_cnt, d0);
    ready_mode = 0;
    run_req(1, 0, 1);

    // Random contents, random blocks, random backpressure
    for (int a = 0; a < 65536; a++) res_mem[a] = 8'($urandom);
    ready_mode = 2;
    for (int n = 0; n < 10; n++) begin
      int b;
      b = int'($urandom_range(0, 8191));
      if (n < 6) b = b % 4096;
      run_req(b, b >= 4096, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/residue_reader_luma4x4.md
Name: residue_reader_luma4x4

Overview:
- Read-back counterpart of the luma 4x4 intra mode/residue saver.
- Given a 4x4 block number, fetches the stored 3-bit prediction mode and the 16 stored 8-bit residues from the frame residue and mode memories.
- Streams them with a valid/ready handshake to downstream transform/entropy stages.
- Drives synchronous-read RAM ports (1-cycle latency) and absorbs downstream backpressure with a 2-entry output buffer.

Parameters:
- LENGTH, 256: frame height in luma samples; multiple of 4.
- WIDTH, 256: frame width in luma samples; power of two, >= 4.
- ADDR_W, 16: residue memory address width; must satisfy 2^ADDR_W >= LENGTH*WIDTH.
- BLK_W, 13: block number width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- blknumber  in  BLK_W  4x4 block index, raster order over the frame's (WIDTH/4)-wide block grid
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at end of request
- err  out  1  valid with done; 1 = blknumber out of range
- mode_rd_en  out  1  mode memory read enable
- mode_addr  out  BLK_W  mode memory address (= latched blknumber)
- mode_rdata  in  3  mode memory data, valid the cycle after mode_rd_en
- res_rd_en  out  1  residue memory read enable
- res_addr  out  ADDR_W  residue memory address
- res_rdata  in  8  residue data, valid the cycle after res_rd_en
- out_valid  out  1  stream sample valid
- out_ready  in  1  downstream ready
- out_data  out  8  residue sample
- out_idx  out  4  raster position inside block (i*4+j)
- out_mode  out  3  mode of current block; held stable for the whole request
- out_last  out  1  marks the 16th sample

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; output buffer empty; sample counter 0. A reset asserted during any state aborts the request at once: no done pulse, buffered samples are discarded.
- Geometry:
  - BPR = WIDTH/4 blocks per row; NBLK = BPR*(LENGTH/4).
  - brow = blknumber / BPR; bcol = blknumber % BPR (shift/mask).
  - Base address = (brow*4)*WIDTH + bcol*4.
  - Sample k (i = k>>2, j = k&3) is at base + i*WIDTH + j.
  - All address arithmetic is at least ADDR_W+2 bits wide; the result is truncated to ADDR_W.
- FSM states:
  - IDLE: start=1 latches blknumber, then:
    - if blknumber >= NBLK, go to ERR;
    - otherwise go to MODE.
  - ERR: for one cycle, done=1 and err=1. No memory reads are issued. Return to IDLE.
  - MODE: assert mode_rd_en for one cycle, then go to MLAT.
  - MLAT: latch mode_rdata into out_mode, then go to STREAM.
  - STREAM:
    - Issue res_rd_en with the address of the next sample only when (buffer occupancy + reads in flight) < 2. At most 1 read is in flight.
    - Returned data is written into the buffer in the cycle after res_rd_en.
    - The head of the buffer drives out_data, out_idx, and out_last (out_last high when idx is the 16th in issue order).
    - A handshake is out_valid & out_ready. Buffer occupancy is one of 0, 1, 2; a push and a pop in the same cycle leave occupancy unchanged.
    - After the 16th handshake, go to DONE.
  - DONE: for one cycle, done=1 and err=0. Return to IDLE.
- start is ignored while busy. A start in the same cycle as the done pulse is also ignored.
- out_valid may not drop, and out_data/out_idx may not change, until the handshake completes.
- Latency with out_ready held at 1:
  - start sampled at cycle 0;
  - mode_rd_en at cycle 1;
  - first res_rd_en at cycle 3;
  - first out_valid at cycle 4;
  - one sample per cycle, last at cycle 19;
  - done at cycle 20.
- Total requests with continuous ready: 21 cycles, start to IDLE.
- Exactly 16 res_rd_en pulses per valid request; each address is read exactly once.

Optional Feature:
- Macro: RESIDUE_ZIGZAG_EN.
- Defined: samples are issued in 4x4 zig-zag order 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15. out_idx still reports the raster index; out_last accompanies raster index 15 (the 16th sample).
- Undefined: samples are issued in raster order 0..15.

Test Plan:
- WIDTH=LENGTH=256, blknumber=0, out_ready=1, memory filled with addr[7:0], mode=3 → res_addr sequence 0,1,2,3,256,257,...,771; out_data matches; out_mode=3 on every sample; timing exactly as specified; done at cycle 20, err=0.
- blknumber=65 (brow=1, bcol=1) → base address 1028; last address 1799; out_last only on the 16th sample.
- blknumber=4096 (>= NBLK) → done and err at cycle 1; no mode_rd_en; no res_rd_en.
- out_ready toggled 1,0,0,1 repeatedly → no sample lost or duplicated; outputs stable while stalled; occupancy never exceeds 2; still exactly 16 reads.
- reset asserted at the 7th handshake, then a new start with blknumber=1 → no done for the aborted request; the new stream starts at address 4 with out_idx=0.
- With RESIDUE_ZIGZAG_EN defined, blknumber=0 → out_idx sequence 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15; out_last with idx 15; data matches raster addresses.
